// File: rtl/distribution_arbiter.sv
// distribution_arbiter
// Round-robin arbiter and sequencer sharing the single distribution-unit (DU)
// fetch path between the core execute stage (port 0) and the debug/DMA port
// (port 1). One fetch is in flight at a time. The DU stall handshake is
// followed to completion, and a watchdog aborts fetches whose handshake never
// finishes. Every output comes straight from a register.
module distribution_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic [31:0]  addr0,
    input  logic [31:0]  addr1,
    output logic         ack0,
    output logic         ack1,
    output logic [255:0] rsp_data,
    output logic         rsp_err,
    output logic         du_ctrl,
    output logic [31:0]  du_rs1,
    input  logic         du_stall,
    input  logic [255:0] du_result,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESP      = 2'd3
    } state_t;

    // Last timer value before the watchdog fires; the timer is 8 bits wide,
    // and TIMEOUT is limited to 2..255, so the timer never wraps.
    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    state_t         state_r;
    state_t         state_s;
    logic [7:0]     timer_r;
    logic [7:0]     timer_s;
    logic           grant_r;
    logic           grant_s;
    logic           last_grant_r;
    logic           last_grant_s;
    logic           pick_s;
    logic           ack0_r;
    logic           ack0_s;
    logic           ack1_r;
    logic           ack1_s;
    logic [255:0]   rsp_data_r;
    logic [255:0]   rsp_data_s;
    logic           rsp_err_r;
    logic           rsp_err_s;
    logic           du_ctrl_r;
    logic           du_ctrl_s;
    logic [31:0]    du_rs1_r;
    logic [31:0]    du_rs1_s;
    logic           busy_r;
    logic           busy_s;

    // Next-state, arbitration, watchdog and next-output decode.
    always_comb begin
        state_s      = state_r;
        timer_s      = timer_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        ack0_s       = 1'b0;
        ack1_s       = 1'b0;
        rsp_data_s   = rsp_data_r;
        rsp_err_s    = rsp_err_r;
        du_ctrl_s    = 1'b0;
        du_rs1_s     = du_rs1_r;

        // Round-robin choice: on contention take the port not served last.
        if (req0 && req1) begin
            pick_s = ~last_grant_r;
        end else if (req1) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                if (req0 || req1) begin
                    grant_s      = pick_s;
                    last_grant_s = pick_s;
                    du_rs1_s     = pick_s ? addr1 : addr0;
                    du_ctrl_s    = 1'b1;
                    timer_s      = 8'd0;
                    state_s      = ST_WAIT_BUSY;
                end else begin
                    state_s      = ST_IDLE;
                end
            end
            ST_WAIT_BUSY: begin
                if (du_stall) begin
                    timer_s = 8'd0;
                    state_s = ST_WAIT_DONE;
                end else if (timer_r == TIMEOUT_M1) begin
                    rsp_data_s = 256'd0;
                    rsp_err_s  = 1'b1;
                    ack0_s     = ~grant_r;
                    ack1_s     = grant_r;
                    timer_s    = 8'd0;
                    state_s    = ST_RESP;
                end else begin
                    timer_s = timer_r + 8'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (!du_stall) begin
                    // The ack is raised together with the data so both
                    // appear in the same cycle while in RESP.
                    rsp_data_s = du_result;
                    rsp_err_s  = 1'b0;
                    ack0_s     = ~grant_r;
                    ack1_s     = grant_r;
                    timer_s    = 8'd0;
                    state_s    = ST_RESP;
                end else if (timer_r == TIMEOUT_M1) begin
                    rsp_data_s = 256'd0;
                    rsp_err_s  = 1'b1;
                    ack0_s     = ~grant_r;
                    ack1_s     = grant_r;
                    timer_s    = 8'd0;
                    state_s    = ST_RESP;
                end else begin
                    timer_s = timer_r + 8'd1;
                end
            end
            ST_RESP: begin
                timer_s = 8'd0;
                state_s = ST_IDLE;
            end
            default: begin
                timer_s = 8'd0;
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            timer_r      <= 8'd0;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            rsp_data_r   <= 256'd0;
            rsp_err_r    <= 1'b0;
            du_ctrl_r    <= 1'b0;
            du_rs1_r     <= 32'd0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            timer_r      <= timer_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            ack0_r       <= ack0_s;
            ack1_r       <= ack1_s;
            rsp_data_r   <= rsp_data_s;
            rsp_err_r    <= rsp_err_s;
            du_ctrl_r    <= du_ctrl_s;
            du_rs1_r     <= du_rs1_s;
            busy_r       <= busy_s;
        end
    end

    assign ack0     = ack0_r;
    assign ack1     = ack1_r;
    assign rsp_data = rsp_data_r;
    assign rsp_err  = rsp_err_r;
    assign du_ctrl  = du_ctrl_r;
    assign du_rs1   = du_rs1_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_distribution_arbiter.sv
// Self-checking bench for distribution_arbiter: a DU model with normal,
// never-stall and stuck-stall behaviour, and a scoreboard of expected
// responses that is checked whenever an ack appears.
module tb_distribution_arbiter;

    logic         clk;
    logic         reset;
    logic         req0;
    logic         req1;
    logic [31:0]  addr0;
    logic [31:0]  addr1;
    logic         ack0;
    logic         ack1;
    logic [255:0] rsp_data;
    logic         rsp_err;
    logic         du_ctrl;
    logic [31:0]  du_rs1;
    logic         du_stall;
    logic [255:0] du_result;
    logic         busy;

    distribution_arbiter #(.TIMEOUT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .addr0     (addr0),
        .addr1     (addr1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .du_ctrl   (du_ctrl),
        .du_rs1    (du_rs1),
        .du_stall  (du_stall),
        .du_result (du_result),
        .busy      (busy)
    );

    typedef struct {
        logic         port;
        logic [255:0] data;
        logic         err;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp      = 0;
    int n_err      = 0;
    int cyc        = 0;
    int ack_total  = 0;
    int ack_cyc    = 0;
    int prev_ack   = 0;
    int ctrl_cnt   = 0;
    int ctrl_cyc   = 0;
    int hold_mode  = 0;
    int du_mode    = 0;   // 0 normal, 1 never stalls, 2 stall stuck high
    int du_cnt     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] data_for(input logic [31:0] a);
        return {8{a ^ 32'hA5A5_A5B5}};
    endfunction

    // DU model: stall rises one cycle after the start strobe, falls two later.
    always @(posedge clk) begin
        if (du_ctrl) begin
            du_result <= data_for(du_rs1);
            if (du_mode != 1) begin
                du_stall <= 1'b1;
                du_cnt   <= 2;
            end
        end else if (du_mode == 2) begin
            du_cnt <= du_cnt;
        end else if (du_cnt > 1) begin
            du_cnt <= du_cnt - 1;
        end else begin
            du_cnt   <= 0;
            du_stall <= 1'b0;
        end
    end

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic port, input logic [255:0] data, input logic err);
        exp_t e;
        e.port = port;
        e.data = data;
        e.err  = err;
        sb_q.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        if (du_ctrl) begin
            ctrl_cnt++;
            ctrl_cyc = cyc;
        end
        if (ack0 || ack1) begin
            check_val("ack_exclusive", {255'd0, ack0 & ack1}, 256'd0);
            if (sb_q.size() == 0) begin
                check_val("unexpected_ack", 256'd1, 256'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("ack_port", {255'd0, ack1}, {255'd0, e.port});
                check_val("rsp_data", rsp_data, e.data);
                check_val("rsp_err", {255'd0, rsp_err}, {255'd0, e.err});
            end
            prev_ack = ack_cyc;
            ack_cyc  = cyc;
            ack_total++;
            if (hold_mode == 0) begin
                if (ack0) req0 = 1'b0;
                if (ack1) req1 = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic wait_acks(input int n, input int budget, input string tag);
        int target;
        int k;
        target = ack_total + n;
        k = 0;
        while (ack_total < target && k < budget) begin
            step();
            k++;
        end
        if (ack_total < target) begin
            check_val(tag, ack_total, target);
        end
        if (hold_mode != 0) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ack0"},    {255'd0, ack0},    256'd0);
        check_val({tag, "_ack1"},    {255'd0, ack1},    256'd0);
        check_val({tag, "_rsp_data"}, rsp_data,         256'd0);
        check_val({tag, "_rsp_err"}, {255'd0, rsp_err}, 256'd0);
        check_val({tag, "_du_ctrl"}, {255'd0, du_ctrl}, 256'd0);
        check_val({tag, "_du_rs1"},  {224'd0, du_rs1},  256'd0);
        check_val({tag, "_busy"},    {255'd0, busy},    256'd0);
    endtask

    initial begin
        int t0;
        int first_ack;
        int ctrl_before;
        int acks_before;
        int a1;

        reset     = 1'b1;
        req0      = 1'b0;
        req1      = 1'b0;
        addr0     = 32'd0;
        addr1     = 32'd0;
        du_stall  = 1'b0;
        du_result = 256'd0;

        // Reset state
        step();
        step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();

        // Single request on port 0
        addr0 = 32'h0000_0010;
        req0  = 1'b1;
        push_exp(1'b0, {8{32'hA5A5_A5A5}}, 1'b0);
        t0 = cyc;
        step();
        check_val("single_du_ctrl", {255'd0, du_ctrl}, 256'd1);
        check_val("single_du_rs1", {224'd0, du_rs1}, 256'h10);
        check_val("single_busy", {255'd0, busy}, 256'd1);
        step();
        check_val("single_du_ctrl_low", {255'd0, du_ctrl}, 256'd0);
        wait_acks(1, 20, "single_ack_timeout");
        check_val("single_latency", ack_cyc - t0, 5);
        step();
        step();

        // Simultaneous requests after reset: 0, 1, 0 every 6 cycles
        do_reset();
        addr0     = 32'h0000_1000;
        addr1     = 32'h0000_2000;
        hold_mode = 1;
        push_exp(1'b0, data_for(32'h0000_1000), 1'b0);
        push_exp(1'b1, data_for(32'h0000_2000), 1'b0);
        push_exp(1'b0, data_for(32'h0000_1000), 1'b0);
        req0 = 1'b1;
        req1 = 1'b1;
        wait_acks(1, 20, "rr_ack1_timeout");
        hold_mode = 1;
        req0 = 1'b1;
        req1 = 1'b1;
        a1 = ack_cyc;
        hold_mode = 0;
        // keep both held through the next two grants
        hold_mode = 1;
        begin
            int target;
            int k;
            target = ack_total + 2;
            k = 0;
            while (ack_total < target && k < 30) begin
                step();
                k++;
                if (ack_total == target - 1 && k < 30) begin
                    if (ack_cyc != a1 && prev_ack == a1) begin
                        check_val("rr_spacing_1", ack_cyc - a1, 6);
                        a1 = ack_cyc;
                    end
                end
            end
            if (ack_total < target) begin
                check_val("rr_ack3_timeout", ack_total, target);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        hold_mode = 0;
        check_val("rr_spacing_2", ack_cyc - prev_ack, 6);
        step();
        step();
        step();

        // Late arrival of port 1 during port 0's WAIT_DONE
        addr0 = 32'h0000_0040;
        addr1 = 32'h0000_0080;
        push_exp(1'b0, data_for(32'h0000_0040), 1'b0);
        push_exp(1'b1, data_for(32'h0000_0080), 1'b0);
        req0 = 1'b1;
        step();
        ctrl_before = ctrl_cnt;
        step();
        step();
        req1 = 1'b1;
        wait_acks(1, 20, "late_ack0_timeout");
        check_val("late_no_second_ctrl", ctrl_cnt, ctrl_before);
        first_ack = ack_cyc;
        wait_acks(1, 20, "late_ack1_timeout");
        check_val("late_grant_cycle", ctrl_cyc, first_ack + 2);
        step();
        step();

        // Timeout: DU never stalls
        du_mode = 1;
        addr0   = 32'h0000_0100;
        push_exp(1'b0, 256'd0, 1'b1);
        req0 = 1'b1;
        wait_acks(1, 30, "timeout_ack_timeout");
        check_val("timeout_latency", ack_cyc - ctrl_cyc, 8);
        step();
        check_val("timeout_busy_low", {255'd0, busy}, 256'd0);
        step();

        // Stuck stall: abort from WAIT_DONE, then a good request
        du_mode = 2;
        addr0   = 32'h0000_0200;
        push_exp(1'b0, 256'd0, 1'b1);
        req0 = 1'b1;
        wait_acks(1, 30, "stuck_ack_timeout");
        check_val("stuck_latency", ack_cyc - ctrl_cyc, 10);
        du_mode = 0;
        step();
        step();
        step();
        addr1 = 32'h0000_0300;
        push_exp(1'b1, data_for(32'h0000_0300), 1'b0);
        req1 = 1'b1;
        wait_acks(1, 20, "recover_ack_timeout");
        check_val("recover_latency", ack_cyc - ctrl_cyc, 4);
        step();
        step();

        // Reset in WAIT_DONE
        addr0 = 32'h0000_0400;
        req0  = 1'b1;
        step();
        step();
        step();
        reset = 1'b1;
        req0  = 1'b0;
        step();
        check_reset_outputs("midreset");
        reset = 1'b0;
        acks_before = ack_total;
        for (int i = 0; i < 6; i++) begin
            step();
        end
        check_val("midreset_no_ack", ack_total, acks_before);
        addr0     = 32'h0000_0500;
        addr1     = 32'h0000_0600;
        push_exp(1'b0, data_for(32'h0000_0500), 1'b0);
        push_exp(1'b1, data_for(32'h0000_0600), 1'b0);
        hold_mode = 1;
        req0 = 1'b1;
        req1 = 1'b1;
        wait_acks(2, 30, "midreset_ack_timeout");
        hold_mode = 0;
        step();
        step();
        step();
        check_val("scoreboard_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/distribution_arbiter.md
# distribution_arbiter

Round-robin arbiter and sequencer that shares the single distribution unit (DU) fetch path between two requesters: the core execute stage (port 0) and the debug/DMA port (port 1). It accepts level-held requests, issues one DU fetch at a time, follows the DU stall handshake through to completion, and returns the 256-bit distribution word with a one-cycle acknowledge. A watchdog aborts fetches whose DU handshake never completes. The block sits between the requesters and the DU; the DU itself is unchanged.

## Interface
- TIMEOUT, 64: maximum cycles spent in either DU wait state before abort; legal range 2–255.
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req0 / req1  input  1  request; held high until the matching ack pulse.
- addr0 / addr1  input  32  rs1 value for the fetch; stable while req is high.
- ack0 / ack1  output  1  one-cycle completion pulse for the granted port.
- rsp_data  output  256  fetched distribution; valid in the ack cycle, held until the next ack.
- rsp_err  output  1  valid with ack; 1 = timeout abort, rsp_data = 0.
- du_ctrl  output  1  DU start strobe (drives DUCtrl); one cycle per fetch.
- du_rs1  output  32  address to the DU (drives rs1); held for the whole transaction.
- du_stall  input  1  DU busy (du_clk_stall).
- du_result  input  256  DU output word (DU_result).
- busy  output  1  high in every state except IDLE.

## Operation
- All outputs are registered. Reset values: ack0/ack1 = 0, rsp_data = 0, rsp_err = 0, du_ctrl = 0, du_rs1 = 0, busy = 0, state = IDLE, last_grant = 1, timer = 0.
- IDLE:
  - No request: remain in IDLE.
  - One request: grant that port.
  - Both requests: grant the port other than last_grant.
  - On a grant: latch the port index into grant and last_grant, latch its addr into du_rs1, assert du_ctrl for one cycle, and go to WAIT_BUSY.
- WAIT_BUSY:
  - du_stall = 1: go to WAIT_DONE and clear the timer.
  - Otherwise: increment the timer.
- WAIT_DONE:
  - du_stall = 0: capture du_result into rsp_data, clear rsp_err, and go to RESP.
  - Otherwise: increment the timer.
- Timeout: if the timer reaches TIMEOUT−1 in WAIT_BUSY or WAIT_DONE, set rsp_data = 0 and rsp_err = 1, and go to RESP.
- RESP:
  - Pulse ack[grant] for exactly one cycle.
  - Go to IDLE.
- A request that deasserts before its ack is a protocol violation. The transaction still completes and the ack is still issued.
- Requests arriving in any non-IDLE state wait; they are evaluated in the first IDLE cycle.
- last_grant updates only on grant, never on reset mid-transaction except for the reset value.
- Timer is 8 bits. It is cleared on every state entry and never wraps, because TIMEOUT ≤ 255.
- Any unused state encoding returns to IDLE on the next edge with all strobes low.

## Timing
- Let edge E be the first posedge at which the arbiter is in IDLE and samples a request high.
  - E+1: du_ctrl = 1, du_rs1 valid, busy = 1.
  - E+2: du_ctrl = 0.
- With the standard DU (stall rises one cycle after DUCtrl and falls two cycles later, with the result already registered):
  - Latency from E to the ack cycle is 5 cycles.
  - Back-to-back grants occur every 6 cycles, because IDLE costs one cycle.
- The ack cycle and rsp_data update coincide. rsp_data does not change between acks.
- Reset mid-transaction:
  - All outputs take their reset values on the next edge.
  - An in-flight DU operation is abandoned; the DU completes it on its own. The arbiter ignores du_stall until the next grant.
  - The requester must re-request.
- No ack is ever produced for a port that was not granted. ack0 and ack1 are never high together.

## Test plan
- Single request: req0 = 1, addr0 = 0x0000_0010, with a DU model returning 0xA5…A5. Required: du_ctrl pulse at E+1 with du_rs1 = 0x10; ack0 at E+5 with rsp_data = 0xA5…A5 and rsp_err = 0.
- Simultaneous requests after reset: req0 and req1 both held. Required:
  - port 0 is served first, then port 1;
  - then port 0 again;
  - three acks 6 cycles apart, alternating;
  - ack1 never coincides with ack0.
- Late arrival: req1 asserted during port 0's WAIT_DONE. Required: no second du_ctrl until port 0's ack; port 1 is granted in the following IDLE cycle.
- Timeout: DU model that never raises stall, with TIMEOUT = 8. Required: ack0 eight cycles after du_ctrl, rsp_err = 1, rsp_data = 0; busy returns to 0.
- Stuck stall: DU model that holds stall high. Required: abort from WAIT_DONE with rsp_err = 1; a subsequent good request succeeds.
- Reset mid-transaction: assert reset for 1 cycle in WAIT_DONE. Required:
  - all outputs return to reset values on the next edge;
  - no ack is produced;
  - with both requests held after release, port 0 is granted first.
